// File: rtl/axi_rdata_xbar_if.sv
// R-channel bundle for the read-data crossbar: slave-side inputs, master-side
// outputs and the default-slave request port.
interface axi_rdata_xbar_if #(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 2,
  parameter int ID_W   = 4,
  parameter int MSEL_W = $clog2(NUM_M),
  parameter int DATA_W = 32
);
  localparam int IDS_W = ID_W + MSEL_W;

  logic [NUM_S*IDS_W-1:0]  rid_s;
  logic [NUM_S*DATA_W-1:0] rdata_s;
  logic [NUM_S*2-1:0]      rresp_s;
  logic [NUM_S-1:0]        rlast_s;
  logic [NUM_S-1:0]        rvalid_s;
  logic [NUM_S-1:0]        rready_s;

  logic [NUM_M*ID_W-1:0]   rid_m;
  logic [NUM_M*DATA_W-1:0] rdata_m;
  logic [NUM_M*2-1:0]      rresp_m;
  logic [NUM_M-1:0]        rlast_m;
  logic [NUM_M-1:0]        rvalid_m;
  logic [NUM_M-1:0]        rready_m;

  logic                    def_req;
  logic [IDS_W-1:0]        def_id;
  logic [7:0]              def_len;
  logic                    def_full;

  // The crossbar itself takes the slave view.
  modport slave (
    input  rid_s, rdata_s, rresp_s, rlast_s, rvalid_s, rready_m,
    input  def_req, def_id, def_len,
    output rready_s, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m, def_full
  );

  modport master (
    output rid_s, rdata_s, rresp_s, rlast_s, rvalid_s, rready_m,
    output def_req, def_id, def_len,
    input  rready_s, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m, def_full
  );
endinterface

// File: rtl/axi_rdata_xbar.sv
// AXI R-channel crossbar: per-master round-robin arbitration with burst locking,
// plus a built-in default slave that replays queued DECERR bursts.
module axi_rdata_xbar #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int ID_W      = 4,
  parameter int MSEL_W    = $clog2(NUM_M),
  parameter int DATA_W    = 32,
  parameter int DEF_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  axi_rdata_xbar_if.slave  bus
);
  localparam int IDS_W   = ID_W + MSEL_W;
  localparam int NSRC    = NUM_S + 1;
  localparam int SRC_W   = $clog2(NSRC);
  localparam int NSRC_P2 = 1 << SRC_W;
  localparam int QP_W    = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1;
  localparam int QC_W    = $clog2(DEF_DEPTH + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state [NUM_M];
  logic [SRC_W-1:0]   owner [NUM_M];
  logic [SRC_W-1:0]   ptr   [NUM_M];
  logic [SRC_W-1:0]   sel   [NUM_M];
  logic [NUM_M-1:0]   conn, hs, done;

  logic [NSRC_P2-1:0] src_valid, src_last;
  logic [IDS_W-1:0]   src_id   [NSRC_P2];
  logic [DATA_W-1:0]  src_data [NSRC_P2];
  logic [1:0]         src_resp [NSRC_P2];
  logic [NSRC_P2-1:0] req      [NUM_M];

  logic [IDS_W-1:0]   q_id  [DEF_DEPTH];
  logic [7:0]         q_len [DEF_DEPTH];
  logic [QP_W-1:0]    wr_ptr, rd_ptr;
  logic [QC_W-1:0]    q_count;
  logic [7:0]         beat_cnt;
  logic               def_valid, def_last, def_hs, def_pop, def_push, q_full;

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    return (int'(s) == NUM_S) ? '0 : s + SRC_W'(1);
  endfunction

  function automatic logic [QP_W-1:0] next_q(input logic [QP_W-1:0] p);
    return (p == QP_W'(DEF_DEPTH - 1)) ? '0 : p + QP_W'(1);
  endfunction

  assign def_valid    = (q_count != '0);
  assign def_last     = (beat_cnt == q_len[rd_ptr]);
  assign q_full       = (q_count == QC_W'(DEF_DEPTH));
  assign def_pop      = def_hs && def_last;
  assign def_push     = bus.def_req && (!q_full || def_pop);
  assign bus.def_full = q_full;

  // Flatten real slaves and the default slave into one source table; the
  // table is padded to a power of two so a SRC_W-bit select always lands in it.
  always_comb begin
    src_valid = '0;
    src_last  = '0;
    for (int s = 0; s < NSRC_P2; s++) begin
      src_id[s]   = '0;
      src_data[s] = '0;
      src_resp[s] = '0;
    end
    for (int s = 0; s < NUM_S; s++) begin
      src_valid[s] = bus.rvalid_s[s];
      src_id[s]    = bus.rid_s[s*IDS_W +: IDS_W];
      src_data[s]  = bus.rdata_s[s*DATA_W +: DATA_W];
      src_resp[s]  = bus.rresp_s[s*2 +: 2];
      src_last[s]  = bus.rlast_s[s];
    end
    src_valid[NUM_S] = def_valid;
    src_id[NUM_S]    = q_id[rd_ptr];
    src_resp[NUM_S]  = 2'b11;
    src_last[NUM_S]  = def_last;
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      for (int s = 0; s < NSRC_P2; s++) begin
        req[m][s] = src_valid[s] && (src_id[s][IDS_W-1:ID_W] == MSEL_W'(m));
      end
    end
  end

  // A locked master only listens to its owner; otherwise scan from ptr.
  always_comb begin
    int idx;
    idx = 0;
    for (int m = 0; m < NUM_M; m++) begin
      conn[m] = 1'b0;
      sel[m]  = '0;
      if (state[m] == LOCKED) begin
        conn[m] = 1'b1;
        sel[m]  = owner[m];
      end else begin
        for (int k = 0; k < NSRC; k++) begin
          idx = int'(ptr[m]) + k;
          if (idx >= NSRC) idx = idx - NSRC;
          if (!conn[m] && req[m][idx]) begin
            conn[m] = 1'b1;
            sel[m]  = SRC_W'(idx);
          end
        end
      end
      if (!rst) conn[m] = 1'b0;
    end
  end

  always_comb begin
    bus.rvalid_m = '0;
    bus.rlast_m  = '0;
    bus.rid_m    = '0;
    bus.rdata_m  = '0;
    bus.rresp_m  = '0;
    bus.rready_s = '0;
    hs           = '0;
    done         = '0;
    def_hs       = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      if (conn[m]) begin
        bus.rvalid_m[m]                 = src_valid[sel[m]];
        bus.rid_m[m*ID_W +: ID_W]       = src_id[sel[m]][ID_W-1:0];
        bus.rdata_m[m*DATA_W +: DATA_W] = src_data[sel[m]];
        bus.rresp_m[m*2 +: 2]           = src_resp[sel[m]];
        bus.rlast_m[m]                  = src_last[sel[m]];
        hs[m]   = src_valid[sel[m]] && bus.rready_m[m];
        done[m] = hs[m] && src_last[sel[m]];
        if (sel[m] == SRC_W'(NUM_S)) def_hs = def_hs | hs[m];
      end
      for (int s = 0; s < NUM_S; s++) begin
        if (conn[m] && sel[m] == SRC_W'(s)) bus.rready_s[s] = bus.rready_s[s] | bus.rready_m[m];
      end
    end
  end

  // Pointer advances past whichever source just finished a burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < NUM_M; m++) begin
        state[m] <= IDLE;
        owner[m] <= '0;
        ptr[m]   <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        case (state[m])
          IDLE: begin
            if (conn[m]) begin
              if (done[m]) begin
                ptr[m] <= next_src(sel[m]);
              end else begin
                state[m] <= LOCKED;
                owner[m] <= sel[m];
              end
            end
          end
          LOCKED: begin
            if (done[m]) begin
              state[m] <= IDLE;
              ptr[m]   <= next_src(owner[m]);
            end
          end
          default: state[m] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      beat_cnt <= '0;
    end else begin
      if (def_push) wr_ptr <= next_q(wr_ptr);
      if (def_pop)  rd_ptr <= next_q(rd_ptr);
      case ({def_push, def_pop})
        2'b10:   q_count <= q_count + QC_W'(1);
        2'b01:   q_count <= q_count - QC_W'(1);
        default: q_count <= q_count;
      endcase
      if (def_hs) beat_cnt <= def_last ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (def_push) begin
      q_id[wr_ptr]  <= bus.def_id;
      q_len[wr_ptr] <= bus.def_len;
    end
  end
endmodule

// File: tb/tb_axi_rdata_xbar.sv
// Bench for axi_rdata_xbar: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of slaves, default slave and arbiters.
module tb_axi_rdata_xbar;
  localparam int NUM_M = 2, NUM_S = 2, ID_W = 4, MSEL_W = 1, DATA_W = 32, DEF_DEPTH = 2;
  localparam int IDS_W = ID_W + MSEL_W;
  localparam int NSRC  = NUM_S + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rdata_xbar_if #(.NUM_M(NUM_M), .NUM_S(NUM_S), .ID_W(ID_W), .MSEL_W(MSEL_W), .DATA_W(DATA_W)) bus ();

  axi_rdata_xbar #(.NUM_M(NUM_M), .NUM_S(NUM_S), .ID_W(ID_W), .MSEL_W(MSEL_W),
                   .DATA_W(DATA_W), .DEF_DEPTH(DEF_DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [IDS_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } beat_t;
  typedef struct { logic [IDS_W-1:0] id; logic [7:0] len; } dreq_t;

  beat_t            sq [NUM_S][$];
  dreq_t            dq [$];
  int               def_beat;
  int               owner [NUM_M];
  int               ptr [NUM_M];
  int               exp_src [NUM_M];
  logic [NUM_S-1:0] s_en;
  logic [NUM_M-1:0] m_rdy;
  bit               push_req, push_on_pop, def_req_drv;
  logic [IDS_W-1:0] push_id;
  logic [7:0]       push_len;
  int               pass_cnt, fail_cnt, total_cnt;
  logic [31:0]      first_data;
  int               hs_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit present(input int s);
    if (s < NUM_S) return s_en[s] && sq[s].size() > 0;
    return dq.size() > 0;
  endfunction

  function automatic int field(input int s);
    if (s < NUM_S) return int'(sq[s][0].id[IDS_W-1]);
    return int'(dq[0].id[IDS_W-1]);
  endfunction

  function automatic int pick(input int m);
    int s;
    if (owner[m] >= 0) return owner[m];
    for (int k = 0; k < NSRC; k++) begin
      s = (ptr[m] + k) % NSRC;
      if (present(s) && field(s) == m) return s;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = dq.size() > 0;
    for (int s = 0; s < NUM_S; s++) if (sq[s].size() > 0) b = 1'b1;
    for (int m = 0; m < NUM_M; m++) if (owner[m] >= 0) b = 1'b1;
    return b;
  endfunction

  function automatic void add_burst(input int s, input int m, input int id, input int beats);
    beat_t b;
    for (int i = 0; i < beats; i++) begin
      b.id   = {MSEL_W'(m), ID_W'(id)};
      b.data = $urandom;
      b.resp = 2'($urandom_range(0, 3));
      b.last = (i == beats - 1);
      sq[s].push_back(b);
    end
  endfunction

  function automatic void push_def(input logic [IDS_W-1:0] id, input logic [7:0] len);
    push_req = 1'b1;
    push_id  = id;
    push_len = len;
  endfunction

  // Drive one cycle of slave/master/default-request inputs and settle.
  task automatic apply_stimulus();
    bit pop_pred;
    @(posedge clk);
    #1;
    for (int s = 0; s < NUM_S; s++) begin
      if (sq[s].size() > 0) begin
        bus.rvalid_s[s]                 = s_en[s];
        bus.rid_s[s*IDS_W +: IDS_W]     = sq[s][0].id;
        bus.rdata_s[s*DATA_W +: DATA_W] = sq[s][0].data;
        bus.rresp_s[s*2 +: 2]           = sq[s][0].resp;
        bus.rlast_s[s]                  = sq[s][0].last;
      end else begin
        bus.rvalid_s[s]                 = 1'b0;
        bus.rid_s[s*IDS_W +: IDS_W]     = '0;
        bus.rdata_s[s*DATA_W +: DATA_W] = '0;
        bus.rresp_s[s*2 +: 2]           = '0;
        bus.rlast_s[s]                  = 1'b0;
      end
    end
    bus.rready_m = m_rdy;
    for (int m = 0; m < NUM_M; m++) exp_src[m] = pick(m);
    pop_pred = 1'b0;
    for (int m = 0; m < NUM_M; m++)
      if (exp_src[m] == NUM_S && dq.size() > 0 && m_rdy[m] && def_beat == int'(dq[0].len)) pop_pred = 1'b1;
    def_req_drv = 1'b0;
    if (push_req) begin
      def_req_drv = 1'b1;
      push_req    = 1'b0;
    end else if (push_on_pop && pop_pred) begin
      def_req_drv = 1'b1;
      push_on_pop = 1'b0;
    end
    bus.def_req = def_req_drv;
    bus.def_id  = push_id;
    bus.def_len = push_len;
    #3;
  endtask

  // Compare every output against the model, then advance the model.
  task automatic check_output();
    int    s, dsize;
    bit    exp_r, popped, done;
    beat_t b;
    for (int m = 0; m < NUM_M; m++) begin
      s = exp_src[m];
      if (s < 0) begin
        check($sformatf("idle_rvalid_m%0d", m), 32'(bus.rvalid_m[m]), 32'(0));
        check($sformatf("idle_rid_m%0d", m), 32'(bus.rid_m[m*ID_W +: ID_W]), 32'(0));
        check($sformatf("idle_rdata_m%0d", m), bus.rdata_m[m*DATA_W +: DATA_W], 32'(0));
        check($sformatf("idle_rresp_m%0d", m), 32'(bus.rresp_m[m*2 +: 2]), 32'(0));
        check($sformatf("idle_rlast_m%0d", m), 32'(bus.rlast_m[m]), 32'(0));
      end else if (present(s)) begin
        check($sformatf("rvalid_m%0d", m), 32'(bus.rvalid_m[m]), 32'(1));
        if (s < NUM_S) begin
          check($sformatf("rid_m%0d", m), 32'(bus.rid_m[m*ID_W +: ID_W]), 32'(sq[s][0].id[ID_W-1:0]));
          check($sformatf("rdata_m%0d", m), bus.rdata_m[m*DATA_W +: DATA_W], sq[s][0].data);
          check($sformatf("rresp_m%0d", m), 32'(bus.rresp_m[m*2 +: 2]), 32'(sq[s][0].resp));
          check($sformatf("rlast_m%0d", m), 32'(bus.rlast_m[m]), 32'(sq[s][0].last));
        end else begin
          check($sformatf("def_rid_m%0d", m), 32'(bus.rid_m[m*ID_W +: ID_W]), 32'(dq[0].id[ID_W-1:0]));
          check($sformatf("def_rdata_m%0d", m), bus.rdata_m[m*DATA_W +: DATA_W], 32'(0));
          check($sformatf("def_rresp_m%0d", m), 32'(bus.rresp_m[m*2 +: 2]), 32'(3));
          check($sformatf("def_rlast_m%0d", m), 32'(bus.rlast_m[m]), 32'(def_beat == int'(dq[0].len)));
        end
      end else begin
        check($sformatf("stalled_rvalid_m%0d", m), 32'(bus.rvalid_m[m]), 32'(0));
      end
    end
    for (int sl = 0; sl < NUM_S; sl++) begin
      exp_r = 1'b0;
      for (int m = 0; m < NUM_M; m++) if (exp_src[m] == sl) exp_r = exp_r | m_rdy[m];
      check($sformatf("rready_s%0d", sl), 32'(bus.rready_s[sl]), 32'(exp_r));
    end
    check("def_full", 32'(bus.def_full), 32'(dq.size() == DEF_DEPTH));

    dsize  = dq.size();
    popped = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      s = exp_src[m];
      if (s >= 0) begin
        done = 1'b0;
        if (present(s) && m_rdy[m]) begin
          if (s < NUM_S) begin
            b    = sq[s].pop_front();
            done = b.last;
          end else if (def_beat == int'(dq[0].len)) begin
            void'(dq.pop_front());
            def_beat = 0;
            popped   = 1'b1;
            done     = 1'b1;
          end else begin
            def_beat++;
          end
        end
        if (done) begin
          owner[m] = -1;
          ptr[m]   = (s + 1) % NSRC;
        end else begin
          owner[m] = s;
        end
      end
    end
    if (def_req_drv && (dsize < DEF_DEPTH || popped)) dq.push_back('{push_id, push_len});
  endtask

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    while (busy() && c < max_cycles) begin
      apply_stimulus();
      check_output();
      c++;
    end
    check("drain_timeout", 32'(busy()), 32'(0));
  endtask

  // Reset is asserted with the slaves still driving, so outputs must drop on rst alone.
  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_rvalid_m", 32'(bus.rvalid_m), 32'(0));
    check("reset_rready_s", 32'(bus.rready_s), 32'(0));
    check("reset_def_full", 32'(bus.def_full), 32'(0));
    bus.rvalid_s = '0; bus.rid_s = '0; bus.rdata_s = '0; bus.rresp_s = '0; bus.rlast_s = '0;
    bus.rready_m = '0; bus.def_req = 1'b0;
    for (int s = 0; s < NUM_S; s++) sq[s].delete();
    dq.delete();
    def_beat = 0; push_req = 1'b0; push_on_pop = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      owner[m] = -1;
      ptr[m]   = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.rvalid_s = '0; bus.rid_s = '0; bus.rdata_s = '0; bus.rresp_s = '0; bus.rlast_s = '0;
    bus.rready_m = '0; bus.def_req = 1'b0; bus.def_id = '0; bus.def_len = '0;
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    push_id = '0; push_len = '0; def_req_drv = 1'b0;
    s_en = '1; m_rdy = '0;
    reset_dut();

    $display("[TB] single burst");
    m_rdy = 2'b01;
    add_burst(1, 0, 5, 4);
    drain(30);

    $display("[TB] parallel bursts");
    m_rdy = 2'b11;
    add_burst(0, 1, 3, 4);
    add_burst(1, 0, 9, 3);
    drain(30);

    $display("[TB] contention");
    reset_dut();
    add_burst(0, 0, 1, 2);
    add_burst(1, 0, 2, 2);
    first_data = sq[0][0].data;
    apply_stimulus();
    check("contention_ptr0_first", bus.rdata_m[31:0], first_data);
    check_output();
    drain(30);
    reset_dut();
    add_burst(0, 0, 4, 1);
    drain(10);
    add_burst(0, 0, 1, 2);
    add_burst(1, 0, 2, 2);
    first_data = sq[1][0].data;
    apply_stimulus();
    check("contention_ptr1_first", bus.rdata_m[31:0], first_data);
    check_output();
    drain(30);

    $display("[TB] backpressure");
    hs_seen = 0;
    add_burst(1, 0, 7, 3);
    for (int i = 0; i < 10; i++) begin
      m_rdy = (i % 2 == 0) ? 2'b01 : 2'b00;
      apply_stimulus();
      if (bus.rvalid_m[0] && bus.rready_m[0]) hs_seen++;
      check_output();
    end
    check("backpressure_handshakes", 32'(hs_seen), 32'(3));

    $display("[TB] default slave");
    m_rdy = 2'b11;
    push_def({1'b1, 4'hA}, 8'd2);
    drain(20);
    check("def_full_after_default", 32'(bus.def_full), 32'(0));

    $display("[TB] default queue full");
    m_rdy = 2'b00;
    push_def({1'b0, 4'h1}, 8'd1);
    apply_stimulus(); check_output();
    push_def({1'b0, 4'h2}, 8'd0);
    apply_stimulus(); check_output();
    push_def({1'b0, 4'h3}, 8'd3);
    apply_stimulus(); check_output();
    check("def_full_when_full", 32'(bus.def_full), 32'(1));
    push_id = {1'b1, 4'h4}; push_len = 8'd1; push_on_pop = 1'b1;
    m_rdy = 2'b11;
    for (int c = 0; c < 20 && push_on_pop; c++) begin
      apply_stimulus();
      check_output();
    end
    check("push_on_pop_timeout", 32'(push_on_pop), 32'(0));
    apply_stimulus();
    check("def_full_after_push_pop", 32'(bus.def_full), 32'(1));
    check_output();
    drain(30);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < NUM_S; s++) begin
        if (sq[s].size() == 0 && $urandom_range(0, 2) == 0)
          add_burst(s, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(1, 4));
        s_en[s] = ($urandom_range(0, 3) != 0);
      end
      m_rdy = 2'($urandom_range(0, 3));
      if (!push_req && $urandom_range(0, 7) == 0)
        push_def({1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))}, 8'($urandom_range(0, 3)));
      apply_stimulus();
      check_output();
    end
    s_en = '1;
    m_rdy = 2'b11;
    drain(300);

    $display("[TB] reset mid-burst");
    push_def({1'b0, 4'h6}, 8'd5);
    add_burst(1, 1, 8, 4);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output();
    end
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus();
      check_output();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/axi_rdata_xbar.md
Name: axi_rdata_xbar

Overview:
- Parametrised AXI read-data (R) channel crossbar: routes R beats from NUM_S slaves to NUM_M masters.
- The destination master is decoded from the upper bits of the slave-side ID.
- Each master has an independent round-robin arbiter with burst locking, so two masters can receive from different slaves in the same cycle.
- Contains the built-in default (decode-error) slave, which replays queued DECERR bursts of the requested length.

Parameters:
- NUM_M, 2, number of masters (≥2).
- NUM_S, 2, number of real slaves (≥1); the default slave is source index NUM_S.
- ID_W, 4, master-side ID width.
- MSEL_W, $clog2(NUM_M), master-select bits prepended to the ID; slave-side ID width IDS_W = ID_W+MSEL_W.
- DATA_W, 32, data width.
- DEF_DEPTH, 2, default-slave request queue depth (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rid_s  in  NUM_S*IDS_W  slave RID; bits [IDS_W-1:ID_W] = master index.
- rdata_s  in  NUM_S*DATA_W  slave RDATA.
- rresp_s  in  NUM_S*2  slave RRESP.
- rlast_s  in  NUM_S  slave RLAST.
- rvalid_s  in  NUM_S  slave RVALID.
- rready_s  out  NUM_S  slave RREADY.
- rid_m  out  NUM_M*ID_W  master RID.
- rdata_m  out  NUM_M*DATA_W  master RDATA.
- rresp_m  out  NUM_M*2  master RRESP.
- rlast_m  out  NUM_M  master RLAST.
- rvalid_m  out  NUM_M  master RVALID.
- rready_m  in  NUM_M  master RREADY.
- def_req  in  1  push a decode-error read burst (from the AR decoder).
- def_id  in  IDS_W  full slave-side ID of that burst.
- def_len  in  8  ARLEN of that burst (beats = def_len+1).
- def_full  out  1  default queue full.

Behaviour:
- Reset (rst=0, async): all per-master locks cleared, round-robin pointers reset to 0, default queue emptied, beat counter reset to 0. Outputs: rvalid_m=0, rready_s=0, def_full=0. Reset mid-burst abandons the burst; no further beats are issued for it.
- Request: source s (0..NUM_S-1) requests master m when rvalid_s[s]=1 and rid_s[s] master field == m. The default source requests m when the queue is non-empty and the head ID master field == m. A master field ≥ NUM_M is never granted, and that source stalls.
- Per-master FSM, states IDLE / LOCKED(owner):
  - IDLE: combinational round-robin pick among requesters, starting at ptr[m] and wrapping modulo NUM_S+1. The granted source drives master m in the same cycle, so the first beat has zero bubble. If that beat is not a completed last beat, next state is LOCKED(granted).
  - LOCKED: only the owner is routed. It returns to IDLE on the cycle where rvalid_m & rready_m & rlast_m are all 1. ptr[m] <= owner+1 (mod NUM_S+1) whenever a burst completes, including a single-beat burst granted from IDLE.
- A slave is routed to at most one master per cycle; its ID fixes the destination, so no conflict arises.
- Routing when connected: rvalid_m = source valid; rready_s = rready_m; rid_m = source ID[ID_W-1:0]; rdata, rresp and rlast pass through.
- When not connected: rvalid_m=0, rid_m=0, rdata_m=0, rresp_m=0, rlast_m=0, rready_s=0. All outputs are fully assigned every cycle, so no latches are inferred.
- Default slave:
  - FIFO of {def_id, def_len}.
  - When the head is connected: RVALID=1, RDATA=0, RRESP=2'b11 (DECERR), RID=head ID, RLAST=(beat counter == head len).
  - The beat counter increments on each handshake. On the last handshake the counter clears to 0 and the head pops.
- Queue boundaries:
  - def_full=1 when count==DEF_DEPTH.
  - Push while full, with no pop in the same cycle, is dropped; the AR side must hold off on def_full.
  - Push and pop in the same cycle when full is accepted; count is unchanged.
  - Pointers wrap modulo DEF_DEPTH.
- A slave dropping rvalid mid-burst keeps the lock; the master sees rvalid_m=0 until the slave resumes.

Test Plan:
- Single burst: slave1 sends a 4-beat burst, ID master field 0, ID=4'h5, rready_m0=1 -> m0 sees 4 beats with rid=5, rlast only on beat 4, rready_s1 mirrors rready_m0, m1 idle.
- Parallel: s0 sends to m1 while s1 sends to m0, same cycles -> both masters receive concurrently with no cross-talk.
- Contention: s0 and s1 both target m0 with 2-beat bursts, ptr=0 -> s0 burst completes first (no interleave), then s1. Repeat after reset with s1 target first -> ptr=1 grants s1.
- Backpressure: rready_m0 toggles 1,0,1,0 during a 3-beat burst -> data held stable while stalled, exactly 3 handshakes, lock released after the last.
- Default slave: def_req with def_id master field 1, ID=4'hA, def_len=2 -> m1 receives 3 beats, RRESP=2'b11, RDATA=0, rid=A, rlast on the 3rd; def_full=0 afterwards.
- Queue full: push DEF_DEPTH requests with rready_m=0 -> def_full=1 and an extra push is dropped. Push on the cycle a final beat pops -> accepted, def_full stays 1. Assert rst low mid-burst -> rvalid_m=0 immediately, queue empty.
